// File: rtl/dac_spi_writer.sv
// dac_spi_writer: write-side SPI master for the LTC2624 quad 12-bit DAC.
// Shifts one 32-bit frame {8'h00, cmd, addr, data, 4'h0} MSB-first, SCK idle low,
// and generates timed DAC_CLR pulses on request.
// Optional build macro DAC_READBACK_EN adds the DAC_OUT input and the
// echo_word/echo_valid readback outputs.
// All outputs are registered and decoded from the current state, so they
// appear one clk after the state that produces them.
module dac_spi_writer #(
  parameter int unsigned HALF       = 2,
  parameter int unsigned CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [3:0]  addr,
  input  logic [11:0] data,
  input  logic        clr_req,
`ifdef DAC_READBACK_EN
  input  logic        DAC_OUT,
  output logic [31:0] echo_word,
  output logic        echo_valid,
`endif
  output logic        ready,
  output logic        done,
  output logic        spi_active,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        DAC_CLR
);

  localparam int unsigned FW        = 32;
  localparam int unsigned MAXC      = (HALF > CLR_CYCLES) ? HALF : CLR_CYCLES;
  localparam int unsigned CW        = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_CLEAR
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          phase, phase_d;   // 0: SCK low half, 1: SCK high half
  logic [4:0]    bitn, bitn_d;
  logic [FW-1:0] word, word_d;
  logic          fin, fin_d;       // frame just finished; becomes done next clk
  logic          ready_d, done_d, active_d, sck_d, mosi_d, cs_d, clr_n_d;
  logic          take;

  assign take = (state == S_IDLE) && ready && start;

  // State, counters, frame word and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      bitn       <= '0;
      word       <= '0;
      fin        <= 1'b0;
      ready      <= 1'b0;
      done       <= 1'b0;
      spi_active <= 1'b0;
      SPI_SCK    <= 1'b0;
      SPI_MOSI   <= 1'b0;
      DAC_CS     <= 1'b1;
      DAC_CLR    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      phase      <= phase_d;
      bitn       <= bitn_d;
      word       <= word_d;
      fin        <= fin_d;
      ready      <= ready_d;
      done       <= done_d;
      spi_active <= active_d;
      SPI_SCK    <= sck_d;
      SPI_MOSI   <= mosi_d;
      DAC_CS     <= cs_d;
      DAC_CLR    <= clr_n_d;
    end
  end

  // Next-state, counter sequencing and output decode
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    phase_d  = phase;
    bitn_d   = bitn;
    word_d   = word;
    fin_d    = 1'b0;
    ready_d  = 1'b0;
    done_d   = fin;
    active_d = 1'b0;
    sck_d    = 1'b0;
    mosi_d   = 1'b0;
    cs_d     = 1'b1;
    clr_n_d  = 1'b1;
    case (state)
      S_IDLE: begin
        ready_d = 1'b1;
        if (take) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          word_d  = {8'h00, cmd, addr, data, 4'h0};
          ready_d = 1'b0;
        end else if (ready && clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      S_SETUP: begin
        cs_d     = 1'b0;
        active_d = 1'b1;
        mosi_d   = word[FW-1];
        if (cnt == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          bitn_d  = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        cs_d     = 1'b0;
        active_d = 1'b1;
        sck_d    = phase;
        mosi_d   = word[~bitn];
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (!phase) begin
            phase_d = 1'b1;
          end else if (bitn == 5'd31) begin
            state_d = S_HOLD;
          end else begin
            bitn_d  = bitn + 5'd1;
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        cs_d     = 1'b0;
        active_d = 1'b1;
        mosi_d   = word[0];
        if (cnt == HALF_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == HALF_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_CLEAR: begin
        clr_n_d = 1'b0;
        if (cnt == CLR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DAC_READBACK_EN
  logic [FW-1:0] rx;

  // Capture DAC_OUT on every SCK rising edge; publish alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      rx         <= '0;
      echo_word  <= '0;
      echo_valid <= 1'b0;
    end else begin
      if (take) begin
        rx <= '0;
      end else if (sck_d && !SPI_SCK) begin
        rx <= {rx[FW-2:0], DAC_OUT};
      end
      echo_valid <= done_d;
      if (done_d) begin
        echo_word <= rx;
      end
    end
  end
`endif

endmodule
